// File: rtl/brainfuck_pkg.sv
// Shared constants and types for the brainfuck program loader and its receiver.
package brainfuck_pkg;

  localparam logic [7:0] BF_INC        = 8'h2B;
  localparam logic [7:0] BF_DEC        = 8'h2D;
  localparam logic [7:0] BF_LEFT       = 8'h3C;
  localparam logic [7:0] BF_RIGHT      = 8'h3E;
  localparam logic [7:0] BF_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] BF_LOOP_CLOSE = 8'h5D;
  localparam logic [7:0] BF_OUT        = 8'h2E;
  localparam logic [7:0] BF_IN         = 8'h2C;
  localparam logic [7:0] BF_TERM       = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } rx_state_t;

  function automatic logic is_bf_instr(input logic [7:0] b);
    case (b)
      BF_INC, BF_DEC, BF_LEFT, BF_RIGHT,
      BF_LOOP_OPEN, BF_LOOP_CLOSE, BF_OUT, BF_IN: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// 8N1 receiver advanced only on bit-rate ticks; byte and status pulses are combinational
// on the stop-bit tick, so the consumer can register the write one cycle later.
module uart_rx_tick
  import brainfuck_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic       abort,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       frame_err
);

  rx_state_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_vld    = 1'b0;
    frame_err = 1'b0;
    // Abort wins over a same-cycle tick, which drops a byte finishing on the close edge.
    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {rx, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (rx) rx_vld    = 1'b1;
          else    frame_err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_dat = shift_q;

endmodule

// File: rtl/brainfuck_loader.sv
// Serial program loader: writes received bytes to sequential addresses, 0x00 terminator on close.
// BF_FILTER_EN keeps only the eight instruction characters; otherwise every valid byte is stored.
module brainfuck_loader
  import brainfuck_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              sysClk,
  input  logic              reset,
  input  logic              uartEn,
  input  logic              loading,
  input  logic              rx,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memData,
  output logic [ADDR_W:0]   progLen,
  output logic              full,
  output logic              frameErr,
  output logic              loadDone
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic              loading_q, loading_d;
  logic              close_q, close_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              full_q, full_d;
  logic              frame_err_q, frame_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              load_done_q, load_done_d;

  logic       win_open, win_close;
  logic [7:0] rx_dat;
  logic       rx_vld, rx_fe;
  logic       filter_ok;

  assign win_open  = loading && !loading_q;
  assign win_close = !loading && loading_q;

  uart_rx_tick u_rx (
    .clk       (sysClk),
    .rst_n     (reset),
    .tick      (uartEn),
    .rx        (rx),
    .abort     (!loading),
    .rx_dat    (rx_dat),
    .rx_vld    (rx_vld),
    .frame_err (rx_fe)
  );

`ifdef BF_FILTER_EN
  assign filter_ok = is_bf_instr(rx_dat);
`else
  assign filter_ok = 1'b1;
`endif

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      loading_q   <= 1'b0;
      close_q     <= 1'b0;
      ptr_q       <= '0;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      loading_q   <= loading_d;
      close_q     <= close_d;
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    loading_d   = loading;
    close_d     = win_close;
    ptr_d       = ptr_q;
    full_d      = full_q;
    frame_err_d = frame_err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    load_done_d = 1'b0;
    if (win_open) begin
      ptr_d       = '0;
      full_d      = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (rx_fe) frame_err_d = 1'b1;
      // The receiver is held in abort while loading is low, so no data byte can race the terminator.
      if (close_q) begin
        load_done_d = 1'b1;
        if (!full_q) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q[ADDR_W-1:0];
          mem_data_d = BF_TERM;
        end
      end else if (rx_vld && filter_ok && (ptr_q < CAPACITY)) begin
        mem_we_d   = 1'b1;
        mem_addr_d = ptr_q[ADDR_W-1:0];
        mem_data_d = rx_dat;
        ptr_d      = ptr_q + PTR_ONE;
        if (ptr_d == CAPACITY) full_d = 1'b1;
      end
    end
  end

  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memData  = mem_data_q;
  assign progLen  = ptr_q;
  assign full     = full_q;
  assign frameErr = frame_err_q;
  assign loadDone = load_done_q;

endmodule

// File: tb/tb_brainfuck_loader.sv
// Scoreboard bench for brainfuck_loader: expected writes queued as bytes are sent, popped on memWe.
module tb_brainfuck_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dat;
  } wr_t;

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              uart_en = 1'b0;
  logic              loading = 1'b0;
  logic              rx      = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [ADDR_W:0]   prog_len;
  logic              full;
  logic              frame_err;
  logic              load_done;

  wr_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  exp_ptr = 0;
  int  tick_cnt = 0;
  logic prev_we = 1'b0;

  brainfuck_loader #(.ADDR_W(ADDR_W)) dut (
    .sysClk   (sys_clk),
    .reset    (rst_n),
    .uartEn   (uart_en),
    .loading  (loading),
    .rx       (rx),
    .memWe    (mem_we),
    .memAddr  (mem_addr),
    .memData  (mem_data),
    .progLen  (prog_len),
    .full     (full),
    .frameErr (frame_err),
    .loadDone (load_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
    uart_en  = (tick_cnt == 0);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp_v, $time);
  endtask

  function automatic bit tb_accepts(input logic [7:0] b);
`ifdef BF_FILTER_EN
    return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
`else
    return 1'b1;
`endif
  endfunction

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge sys_clk) begin
    if (mem_we) begin
      wr_t e;
      chk("we_gap", {31'd0, prev_we}, 32'd0);
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", {28'd0, mem_addr}, {28'd0, e.addr});
        chk("wr_data", {24'd0, mem_data}, {24'd0, e.dat});
      end
    end
    prev_we = mem_we;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic wait_tick();
    do @(posedge sys_clk); while (uart_en !== 1'b1);
  endtask

  task automatic send_start_bits(input logic [7:0] b, input int nbits);
    @(negedge sys_clk) rx = 1'b0;
    wait_tick();
    for (int i = 0; i < nbits; i++) begin
      @(negedge sys_clk) rx = b[i];
      wait_tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    send_start_bits(b, 8);
    if (good_stop && tb_accepts(b) && exp_ptr < CAP) begin
      sb.push_back('{addr: exp_ptr[ADDR_W-1:0], dat: b});
      exp_ptr++;
    end
    @(negedge sys_clk) rx = good_stop;
    wait_tick();
    @(negedge sys_clk) rx = 1'b1;
  endtask

  task automatic open_window();
    @(negedge sys_clk) loading = 1'b1;
    exp_ptr = 0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic close_window();
    int   n_done;
    logic we_at_done;
    bit   term;
    n_done     = 0;
    we_at_done = 1'b0;
    term       = (exp_ptr < CAP);
    if (term) sb.push_back('{addr: exp_ptr[ADDR_W-1:0], dat: 8'h00});
    @(negedge sys_clk) loading = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (load_done) begin
        n_done++;
        we_at_done = mem_we;
      end
    end
    chk("load_done_pulses", n_done, 1);
    chk("term_with_done", {31'd0, we_at_done}, {31'd0, term});
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_we",       {31'd0, mem_we},    0);
    chk("rst_addr",     {28'd0, mem_addr},  0);
    chk("rst_data",     {24'd0, mem_data},  0);
    chk("rst_len",      {27'd0, prog_len},  0);
    chk("rst_full",     {31'd0, full},      0);
    chk("rst_ferr",     {31'd0, frame_err}, 0);
    chk("rst_done",     {31'd0, load_done}, 0);
    @(negedge sys_clk) rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // "+[.+]"
    open_window();
    send_byte(8'h2B, 1'b1);
    send_byte(8'h5B, 1'b1);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h2B, 1'b1);
    send_byte(8'h5D, 1'b1);
    chk("prog_len_5", {27'd0, prog_len}, 5);
    close_window();
    chk("prog_len_after_close", {27'd0, prog_len}, 5);
    chk("full_prog", {31'd0, full}, 0);
    chk("ferr_prog", {31'd0, frame_err}, 0);

    // Non-instruction byte then '+'
    open_window();
    send_byte(8'h61, 1'b1);
    send_byte(8'h2B, 1'b1);
`ifdef BF_FILTER_EN
    chk("prog_len_filter", {27'd0, prog_len}, 1);
`else
    chk("prog_len_nofilter", {27'd0, prog_len}, 2);
`endif
    close_window();

    // Framing error, then a good byte still lands at 0
    open_window();
    send_byte(8'h2D, 1'b0);
    chk("ferr_set", {31'd0, frame_err}, 1);
    chk("ferr_no_write", {27'd0, prog_len}, 0);
    send_byte(8'h2B, 1'b1);
    chk("ferr_sticky", {31'd0, frame_err}, 1);
    close_window();
    open_window();
    chk("ferr_cleared", {31'd0, frame_err}, 0);
    chk("len_cleared", {27'd0, prog_len}, 0);
    close_window();

    // Fill memory, one byte past capacity
    open_window();
    for (int i = 0; i <= CAP; i++) begin
      send_byte(8'h2B, 1'b1);
      if (i == CAP - 2) chk("not_full_yet", {31'd0, full}, 0);
      if (i == CAP - 1) begin
        chk("full_set", {31'd0, full}, 1);
        chk("len_cap", {27'd0, prog_len}, CAP);
      end
    end
    chk("len_after_drop", {27'd0, prog_len}, CAP);
    chk("full_after_drop", {31'd0, full}, 1);
    close_window();
    chk("len_full_close", {27'd0, prog_len}, CAP);

    // Close mid-byte: partial '-' discarded, terminator at 0
    open_window();
    chk("full_cleared", {31'd0, full}, 0);
    send_start_bits(8'h2D, 4);
    close_window();
    chk("len_partial", {27'd0, prog_len}, 0);

    // Reset mid-byte
    open_window();
    send_byte(8'h2B, 1'b1);
    send_start_bits(8'h3C, 3);
    @(negedge sys_clk);
    chk("pre_rst_len", {27'd0, prog_len}, 1);
    rst_n   = 1'b0;
    loading = 1'b0;
    rx      = 1'b1;
    #1;
    chk("mid_rst_we",   {31'd0, mem_we},    0);
    chk("mid_rst_addr", {28'd0, mem_addr},  0);
    chk("mid_rst_data", {24'd0, mem_data},  0);
    chk("mid_rst_len",  {27'd0, prog_len},  0);
    chk("mid_rst_full", {31'd0, full},      0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 0);
    chk("mid_rst_done", {31'd0, load_done}, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    open_window();
    send_byte(8'h3E, 1'b1);
    chk("post_rst_len", {27'd0, prog_len}, 1);
    close_window();

    repeat (5) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
